// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: receive-side checker for the 4-approach light bus.
// Decodes NS/EW/SN/WE into a phase 0..7 and checks exclusivity, code
// legality, phase order and dwell times. All outputs are registered.
module traffic_light_monitor #(
    parameter int GREEN_CYCLES  = 6,
    parameter int YELLOW_CYCLES = 3,
    parameter int CNT_W         = 8
) (
    input  logic             CLK,
    input  logic             CLEAR,
    input  logic [1:0]       NS,
    input  logic [1:0]       SN,
    input  logic [1:0]       EW,
    input  logic [1:0]       WE,
    output logic [2:0]       PHASE,
    output logic             PHASE_VALID,
    output logic             CONFLICT,
    output logic             BAD_CODE,
    output logic             ALL_RED,
    output logic             SEQ_ERR,
    output logic             TIME_ERR,
    output logic             ERR_STICKY,
    output logic [CNT_W-1:0] ROT_CNT
);

    typedef enum logic {SYNC, TRACK} state_t;

    localparam logic [CNT_W-1:0] G_LIM = CNT_W'(GREEN_CYCLES);
    localparam logic [CNT_W-1:0] Y_LIM = CNT_W'(YELLOW_CYCLES);
    localparam logic [CNT_W-1:0] C_MAX = '1;

    state_t           r_state, w_state;
    logic [2:0]       r_phase, w_phase_nxt;
    logic [CNT_W-1:0] r_dwell, w_dwell;
    logic             r_timed, w_timed;
    logic [CNT_W-1:0] r_rot, w_rot;
    logic             r_cf, r_bc, r_ar, r_se, r_te, r_sticky;
    logic             w_cf, w_bc, w_ar, w_se, w_te;

    // Approaches listed in phase-index order: NS=0, EW=1, SN=2, WE=3.
    logic [3:0][1:0]  w_code;
    logic [2:0]       w_cnt;
    logic [1:0]       w_idx;
    logic             w_yel, w_bad, w_valid;
    logic [2:0]       w_phase;
    logic [CNT_W-1:0] w_limit;

    assign w_code = {WE, SN, EW, NS};

    // Decode the bus: count non-RED approaches, spot illegal codes, build phase.
    always_comb begin
        w_cnt = 3'd0;
        w_idx = 2'd0;
        w_yel = 1'b0;
        w_bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (w_code[i] != 2'b00) begin
                w_cnt = w_cnt + 3'd1;
                w_idx = 2'(i);
                w_yel = (w_code[i] == 2'b01);
            end
            if (w_code[i] == 2'b11) w_bad = 1'b1;
        end
    end

    assign w_valid = (w_cnt == 3'd1) && !w_bad;
    assign w_phase = {w_idx, w_yel};
    // Dwell limit always refers to the phase currently being tracked.
    assign w_limit = r_phase[0] ? Y_LIM : G_LIM;

    // Next-state and pulse logic for the SYNC/TRACK checker.
    always_comb begin
        w_state     = r_state;
        w_phase_nxt = r_phase;
        w_dwell     = r_dwell;
        w_timed     = r_timed;
        w_rot       = r_rot;
        w_cf        = 1'b0;
        w_bc        = 1'b0;
        w_ar        = 1'b0;
        w_se        = 1'b0;
        w_te        = 1'b0;
        if (!w_valid) begin
            w_cf    = (w_cnt > 3'd1);
            w_bc    = w_bad;
            w_ar    = (w_cnt == 3'd0);
            w_state = SYNC;
            w_timed = 1'b0;
        end else if (r_state == SYNC) begin
            // First phase after (re)sync is taken on trust and left untimed.
            w_phase_nxt = w_phase;
            w_dwell     = CNT_W'(1);
            w_timed     = 1'b0;
            w_state     = TRACK;
        end else if (w_phase == r_phase) begin
            if (r_dwell != C_MAX) w_dwell = r_dwell + CNT_W'(1);
            // Overrun is flagged only on the step limit -> limit+1.
            w_te = (r_dwell == w_limit) && (r_dwell != C_MAX);
        end else begin
            w_se = (w_phase != 3'(r_phase + 3'd1));
            // Overrun was already reported while dwelling; only underrun here.
            w_te = r_timed && (r_dwell < w_limit);
            if (r_phase == 3'd7 && w_phase == 3'd0 && !w_se && r_rot != C_MAX)
                w_rot = r_rot + CNT_W'(1);
            w_phase_nxt = w_phase;
            w_dwell     = CNT_W'(1);
            w_timed     = 1'b1;
        end
    end

    // State, tracking registers and one-cycle error pulses.
    always_ff @(posedge CLK or posedge CLEAR) begin
        if (CLEAR) begin
            r_state  <= SYNC;
            r_phase  <= 3'd0;
            r_dwell  <= '0;
            r_timed  <= 1'b0;
            r_rot    <= '0;
            r_cf     <= 1'b0;
            r_bc     <= 1'b0;
            r_ar     <= 1'b0;
            r_se     <= 1'b0;
            r_te     <= 1'b0;
            r_sticky <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_phase  <= w_phase_nxt;
            r_dwell  <= w_dwell;
            r_timed  <= w_timed;
            r_rot    <= w_rot;
            r_cf     <= w_cf;
            r_bc     <= w_bc;
            r_ar     <= w_ar;
            r_se     <= w_se;
            r_te     <= w_te;
            r_sticky <= r_sticky | w_cf | w_bc | w_ar | w_se | w_te;
        end
    end

    assign PHASE       = r_phase;
    assign PHASE_VALID = (r_state == TRACK);
    assign CONFLICT    = r_cf;
    assign BAD_CODE    = r_bc;
    assign ALL_RED     = r_ar;
    assign SEQ_ERR     = r_se;
    assign TIME_ERR    = r_te;
    assign ERR_STICKY  = r_sticky;
    assign ROT_CNT     = r_rot;

endmodule

// File: tb/tb_traffic_light_monitor.sv
module tb_traffic_light_monitor;

    logic       CLK = 1'b0;
    logic       CLEAR;
    logic [1:0] NS, SN, EW, WE;
    logic [2:0] PHASE;
    logic       PHASE_VALID, CONFLICT, BAD_CODE, ALL_RED, SEQ_ERR, TIME_ERR, ERR_STICKY;
    logic [7:0] ROT_CNT;

    traffic_light_monitor #(.GREEN_CYCLES(6), .YELLOW_CYCLES(3), .CNT_W(8)) dut (
        .CLK(CLK), .CLEAR(CLEAR), .NS(NS), .SN(SN), .EW(EW), .WE(WE),
        .PHASE(PHASE), .PHASE_VALID(PHASE_VALID), .CONFLICT(CONFLICT),
        .BAD_CODE(BAD_CODE), .ALL_RED(ALL_RED), .SEQ_ERR(SEQ_ERR),
        .TIME_ERR(TIME_ERR), .ERR_STICKY(ERR_STICKY), .ROT_CNT(ROT_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [17:0] v;
        string       tag;
    } exp_t;

    exp_t sb[$];
    event ev_chk;
    int   n_vec = 0;
    int   n_bad = 0;
    logic       exp_st  = 1'b0;
    logic [7:0] exp_rot = 8'd0;

    localparam logic [4:0] P_NONE = 5'b00000;
    localparam logic [4:0] P_CF   = 5'b10000;
    localparam logic [4:0] P_BC   = 5'b01000;
    localparam logic [4:0] P_AR   = 5'b00100;
    localparam logic [4:0] P_SE   = 5'b00010;
    localparam logic [4:0] P_TE   = 5'b00001;

    task automatic apply(input logic [1:0] ns, input logic [1:0] sn, input logic [1:0] ew,
                         input logic [1:0] we, input logic [2:0] ph, input logic pv,
                         input logic [4:0] pl, input string tag);
        exp_t e;
        NS = ns; SN = sn; EW = ew; WE = we;
        exp_st = exp_st | (|pl);
        e.v   = {ph, pv, pl, exp_st, exp_rot};
        e.tag = tag;
        sb.push_back(e);
        @(negedge CLK);
    endtask

    task automatic apply_p(input int p, input logic [4:0] pl, input string tag);
        logic [1:0] c [4];
        logic [1:0] code;
        for (int i = 0; i < 4; i++) c[i] = 2'b00;
        code = (p % 2 == 1) ? 2'b01 : 2'b10;
        c[p / 2] = code;
        apply(c[0], c[2], c[1], c[3], 3'(p), 1'b1, pl, tag);
    endtask

    task automatic run_rot(input int n);
        for (int r = 0; r < n; r++)
            for (int p = 0; p < 8; p++)
                for (int k = 0; k < ((p % 2 == 1) ? 3 : 6); k++) begin
                    if (p == 0 && k == 0 && r > 0) exp_rot = exp_rot + 8'd1;
                    apply_p(p, P_NONE, "rotation");
                end
    endtask

    task automatic check_cleared(input string tag);
        exp_t e;
        e.v   = '0;
        e.tag = tag;
        sb.push_back(e);
        -> ev_chk;
        #2;
    endtask

    initial begin
        exp_t        e;
        logic [17:0] act;
        forever begin
            @(posedge CLK or ev_chk);
            #1;
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                act = {PHASE, PHASE_VALID, CONFLICT, BAD_CODE, ALL_RED, SEQ_ERR,
                       TIME_ERR, ERR_STICKY, ROT_CNT};
                n_vec++;
                if (act !== e.v) begin
                    n_bad++;
                    $display("FAIL %s @%0t: got ph=%0d pv=%b cf/bc/ar/se/te=%b st=%b rot=%0d, want ph=%0d pv=%b cf/bc/ar/se/te=%b st=%b rot=%0d",
                             e.tag, $time, act[17:15], act[14], act[13:9], act[8], act[7:0],
                             e.v[17:15], e.v[14], e.v[13:9], e.v[8], e.v[7:0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete, %0d vectors pending", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        CLEAR = 1'b1;
        NS = 2'b00; SN = 2'b00; EW = 2'b00; WE = 2'b00;
        repeat (2) @(negedge CLK);
        #2;
        check_cleared("reset state");
        @(negedge CLK);
        CLEAR = 1'b0;

        run_rot(3);
        exp_rot = exp_rot + 8'd1;
        for (int k = 0; k < 6; k++) apply_p(0, P_NONE, "ns green rot3");
        if (ROT_CNT !== 8'd3 || PHASE !== 3'd0) begin
            n_bad++;
            $display("FAIL direct rot3: ROT_CNT=%0d PHASE=%0d", ROT_CNT, PHASE);
        end

        apply_p(2, P_SE, "seq 0->2");
        for (int k = 0; k < 5; k++) apply_p(2, P_NONE, "ew hold");
        apply_p(2, P_TE, "ew overrun 7th");
        for (int k = 0; k < 3; k++) apply_p(3, P_NONE, "ew yellow after overrun");

        apply(2'b10, 2'b00, 2'b10, 2'b00, 3'd3, 1'b0, P_CF, "conflict");
        if (CONFLICT !== 1'b1 || PHASE_VALID !== 1'b0 || ERR_STICKY !== 1'b1) begin
            n_bad++;
            $display("FAIL direct conflict: cf=%b pv=%b st=%b", CONFLICT, PHASE_VALID, ERR_STICKY);
        end
        apply_p(2, P_NONE, "resync ew green");

        apply(2'b00, 2'b00, 2'b00, 2'b11, 3'd2, 1'b0, P_BC, "bad code");
        apply(2'b00, 2'b00, 2'b00, 2'b00, 3'd2, 1'b0, P_AR, "all red");
        apply(2'b11, 2'b00, 2'b10, 2'b00, 3'd2, 1'b0, P_CF | P_BC, "conflict+bad");

        apply_p(0, P_NONE, "sync ns green");
        apply_p(1, P_NONE, "ns yellow untimed");
        apply_p(2, P_TE, "yellow underrun");
        apply_p(2, P_NONE, "ew green 2");
        apply_p(4, P_SE | P_TE, "seq+underrun");
        apply_p(4, P_NONE, "sn green 2");

        CLEAR = 1'b1;
        exp_rot = 8'd0;
        exp_st  = 1'b0;
        @(negedge CLK);
        CLEAR = 1'b0;
        run_rot(2);
        exp_rot = exp_rot + 8'd1;
        apply_p(0, P_NONE, "ns green rot2");
        apply_p(0, P_NONE, "ns green rot2");
        apply(2'b00, 2'b00, 2'b00, 2'b00, 3'd0, 1'b0, P_AR, "all red rot2");
        apply_p(0, P_NONE, "resync rot2");
        apply_p(0, P_NONE, "ns hold rot2");
        #2;
        CLEAR = 1'b1;
        check_cleared("async clear mid-phase");
        if (ROT_CNT !== 8'd0 || ERR_STICKY !== 1'b0 || PHASE_VALID !== 1'b0) begin
            n_bad++;
            $display("FAIL direct async clear: rot=%0d st=%b pv=%b", ROT_CNT, ERR_STICKY, PHASE_VALID);
        end
        @(negedge CLK);
        CLEAR = 1'b0;
        repeat (2) @(negedge CLK);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        if (n_bad == 0 && n_vec > 0) $display("PASS");
        else $display("FAIL");
        $finish;
    end

endmodule
